// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter controller for a multicycle datapath. Owns the
//               PC, fetches each instruction from instruction memory, holds it
//               for decode/execute and selects the next PC. The next PC is the
//               sequential increment, a branch target or a jump target.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}},
    parameter int                 STEP     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] C_STEP       = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] C_ALIGN_MASK = ~ADDR_W'(3);

    state_t            r_state;
    logic [ADDR_W-1:0] w_jmp_aligned;
    logic [ADDR_W-1:0] w_br_aligned;
    logic [ADDR_W-1:0] w_pc_next_seq;

    // Targets are forced to word alignment; the increment wraps naturally
    assign w_jmp_aligned = jmp_target & C_ALIGN_MASK;
    assign w_br_aligned  = br_target & C_ALIGN_MASK;
    assign w_pc_next_seq = pc + C_STEP;

    // Request follows state and stall combinationally; the address is the PC itself
    assign imem_req  = (r_state == S_FETCH) && !stall;
    assign imem_addr = pc;

    // Sequencer: fetch, hold for execute, then pick the next PC by priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= {DATA_W{1'b0}};
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    // An ack that arrives while stalled was never requested
                    if (imem_ack && !stall) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        r_state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        instr_valid <= 1'b0;
                        if (halt) begin
                            halted  <= 1'b1;
                            r_state <= S_HALT;
                        end else begin
                            r_state <= S_FETCH;
                            if (jmp) begin
                                pc <= w_jmp_aligned;
                            end else if (br_taken) begin
                                pc <= w_br_aligned;
                            end else begin
                                pc <= w_pc_next_seq;
                            end
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter controller for the multicycle datapath. Owns the PC register and sequences each instruction through fetch and execute.
- Handshakes with instruction memory and with the decode/execute stage.
- Selects the next PC from three sources: the sequential PC+STEP increment, a branch target, or a jump target.
- Sits between the instruction memory port and the decoder. Replaces the free-running PC+4 path.

Parameters:
- ADDR_W, 32: width of the PC, addresses and targets.
- DATA_W, 32: instruction word width.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- STEP, 4: sequential PC increment in bytes.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- stall, in, 1: holds off new fetch requests while high.
- imem_req, out, 1: fetch request to instruction memory.
- imem_addr, out, ADDR_W: fetch address; equals pc.
- imem_ack, in, 1: memory returns valid imem_rdata this cycle.
- imem_rdata, in, DATA_W: fetched instruction word.
- instr, out, DATA_W: latched instruction for the decoder.
- instr_valid, out, 1: instr is valid and awaiting execution.
- exec_done, in, 1: decoder/execute has finished the current instruction; next-PC inputs are valid this cycle.
- br_taken, in, 1: take br_target.
- br_target, in, ADDR_W: branch target address.
- jmp, in, 1: take jmp_target.
- jmp_target, in, ADDR_W: jump target address.
- halt, in, 1: stop the sequencer after the current instruction.
- pc, out, ADDR_W: current PC.
- halted, out, 1: sequencer is in HALT.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, pc=RESET_PC, instr=0.
  - instr_valid=0, imem_req=0, halted=0.
  - Asserting reset mid-fetch or mid-execute aborts immediately; any pending ack is ignored.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: one cycle after reset release, then unconditionally to FETCH.
- FETCH:
  - imem_req = ~stall; imem_addr = pc.
  - On imem_ack with stall=0: instr <= imem_rdata, instr_valid <= 1, go to EXEC.
  - imem_ack while stall=1 is ignored; remain in FETCH.
  - The request stays asserted, with a stable address, until acked.
- EXEC:
  - imem_req=0; instr_valid=1; instr is held stable.
  - On exec_done, instr_valid <= 0 and next state/PC are chosen by priority:
    - halt: pc unchanged, go to HALT, halted <= 1.
    - else jmp: pc <= {jmp_target[ADDR_W-1:2], 2'b00}.
    - else br_taken: pc <= {br_target[ADDR_W-1:2], 2'b00}.
    - else: pc <= pc + STEP, modulo 2^ADDR_W (0xFFFF_FFFC wraps to 0x0000_0000).
  - Non-halt cases go to FETCH.
  - jmp, br_taken and halt are ignored when exec_done=0.
- HALT: terminal. imem_req=0, instr_valid=0, halted=1. Left only by reset.
- Latency:
  - Ack in the first FETCH cycle and exec_done in the first EXEC cycle gives 2 cycles per instruction.
  - The first imem_req rises 1 cycle after reset release.
- pc changes only on the EXEC→FETCH transition or on reset.
- Outputs are registered, except imem_req (state and stall) and imem_addr (= pc).

Test Plan:
- Reset release, imem_ack tied high, exec_done tied high, no control inputs -> imem_addr sequence 0x0, 0x4, 0x8, 0xC, one new address every 2 cycles; first imem_req 1 cycle after rst_n rises.
- pc=0x10, exec_done with br_taken=1, br_target=0x103 -> next imem_addr=0x100. Repeat with jmp=1, jmp_target=0x200 and br_taken=1 together -> 0x200 (jump wins).
- stall=1 for 5 cycles during FETCH, with imem_ack pulsed in cycle 2 -> imem_req=0 throughout, ack ignored, instr unchanged. After stall drops and an ack with rdata=0xDEADBEEF -> instr=0xDEADBEEF, instr_valid=1.
- RESET_PC=0xFFFF_FFF8, two sequential instructions -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
- exec_done with halt=1 at pc=0x20 -> halted=1, pc stays 0x20, imem_req stays 0 for 20 cycles even with imem_ack toggling.
- rst_n pulsed low during EXEC with instr_valid=1 -> instr_valid and imem_req drop in the same cycle; pc=RESET_PC; refetch starts from RESET_PC after release.
